// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry process one
// operand bit pair per clock, LSB first, producing an N-bit sum plus carry-out.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             c_out
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] r_next;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .c    (carry),
        .sum  (fa_sum),
        .carry(fa_carry)
    );

    // Sum bits enter at the MSB so the LSB-first result lands in order after WIDTH shifts.
    assign r_next = {fa_sum, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        r_sr  <= '0;
                        carry <= c_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    r_sr  <= r_next;
                    carry <= fa_carry;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        S     <= r_next;
                        c_out <= fa_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, random operands and an
// exhaustive 3-bit sweep, all checked against A+B+c_in computed arithmetically.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] s8;

    logic       start3 = 1'b0;
    logic [2:0] a3 = '0;
    logic [2:0] b3 = '0;
    logic       cin3 = 1'b0;
    logic       busy3, done3, cout3;
    logic [2:0] s3;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         done_cyc = 0;
    int         first_done = 0;
    logic [8:0] held8 = '0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .c_in(cin8),
        .busy(busy8), .done(done8), .S(s8), .c_out(cout8)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3), .c_in(cin3),
        .busy(busy3), .done(done3), .S(s3), .c_out(cout3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; poke >= 0 re-asserts start with new operands in that busy cycle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci, input int poke);
        logic [8:0] exp;
        exp = {1'b0, a} + {1'b0, b} + 9'(ci);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int k = 0; k < 8; k++) begin
            check("busy8_during", 64'(busy8), 64'd1);
            check("done8_during", 64'(done8), 64'd0);
            check("hold8_during", 64'({cout8, s8}), 64'(held8));
            if (k == poke) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        check("busy8_end", 64'(busy8), 64'd0);
        check("done8_end", 64'(done8), 64'd1);
        check("sum8", 64'({cout8, s8}), 64'(exp));
        done_cyc = cyc;
        held8 = exp;
    endtask

    task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic ci);
        logic [3:0] exp;
        exp = {1'b0, a} + {1'b0, b} + 4'(ci);
        @(negedge clk);
        a3 = a; b3 = b; cin3 = ci; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("busy3_during", 64'(busy3), 64'd1);
            @(negedge clk);
        end
        check("done3_end", 64'(done3), 64'd1);
        check("sum3", 64'({cout3, s3}), 64'(exp));
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("reset8", 64'({busy8, done8, cout8, s8}), 64'd0);
        check("reset3", 64'({busy3, done3, cout3, s3}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run8(8'h00, 8'h00, 1'b0, -1);
        run8(8'hFF, 8'h01, 1'b0, -1);
        run8(8'hA5, 8'h5A, 1'b1, -1);
        run8(8'h7F, 8'h01, 1'b0, -1);

        run8(8'h10, 8'h20, 1'b0, 3);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("no_second_busy", 64'(busy8), 64'd0);
            check("no_second_done", 64'(done8), 64'd0);
        end

        // Abort an operation with an off-edge reset in its fourth busy cycle.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_outputs", 64'({busy8, done8, cout8, s8}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        held8 = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done8), 64'd0);
            check("abort_idle", 64'(busy8), 64'd0);
        end
        run8(8'h01, 8'h02, 1'b0, -1);

        run8(8'h3C, 8'h4D, 1'b1, -1);
        first_done = done_cyc;
        run8(8'hC8, 8'h64, 1'b0, -1);
        check("b2b_spacing", 64'(done_cyc - first_done), 64'd10);

        for (int n = 0; n < 30; n++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), -1);

        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            v = 7'(i);
            run3(v[2:0], v[5:3], v[6]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder built around a single full-adder cell (sum = A^B^C, carry = majority) plus a registered carry. It sits directly downstream of the one-bit full adder and instantiates that cell. Each cycle it feeds the cell one operand bit pair, LSB first, and feeds the cell's carry-out back as the next carry-in. It trades latency for area against the ripple-carry adder.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request to add; sampled only in IDLE
A  input  WIDTH  operand A, captured on accepted start
B  input  WIDTH  operand B, captured on accepted start
c_in  input  1  carry-in, captured on accepted start
busy  output  1  high while an addition is in progress (SHIFT state)
done  output  1  one-cycle pulse: S/c_out hold a new result
S  output  WIDTH  registered sum
c_out  output  1  registered final carry-out

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high; it acts immediately, independent of clk.
- Reset values: state=IDLE, busy=0, done=0, S=0, c_out=0. Internal registers are also cleared: operand shift registers, carry flop, bit counter.
- States: IDLE, SHIFT, DONE. Encoding is free.
- IDLE, start=1 at a rising edge:
  - load a_sr<=A, b_sr<=B, carry<=c_in, cnt<=0
  - go to SHIFT
- IDLE, start=0: stay in IDLE.
- SHIFT, every edge:
  - the full-adder cell takes a_sr[0], b_sr[0] and carry
  - a_sr and b_sr shift right by one
  - the sum bit enters the MSB of the result shift register r_sr, which shifts right
  - carry<=cell carry-out; cnt<=cnt+1
- SHIFT exit: on the edge where cnt==WIDTH-1 (the WIDTH-th shift), go to DONE and load S<=final r_sr and c_out<=final carry.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE. start is ignored in DONE.
- busy=1 exactly while state==SHIFT. That is WIDTH cycles.
- Latency: start is captured at edge E. done is high during the cycle after edge E+WIDTH. The next start can be accepted at edge E+WIDTH+2 or later.
- S and c_out hold their last result from one completion until the next completion. They do not change during SHIFT.
- start while busy or in DONE is ignored. A, B and c_in changes after capture have no effect.
- Arithmetic: {c_out,S} = A + B + c_in exactly, in WIDTH+1 bits.
  - Unsigned wrap: the overflow bit appears only in c_out.
  - No signed-overflow flag.
- cnt width is $clog2(WIDTH)+1 bits. It must not wrap before WIDTH-1.
- rst mid-operation (in SHIFT or DONE):
  - immediate return to IDLE
  - busy=0, done=0, S=0, c_out=0
  - the partial result is discarded
  - no done pulse is produced for the aborted operation
- rst deasserted with start=1: start is accepted at the first rising edge at which rst is low.

Test Plan:
1. WIDTH=8: A=0x00, B=0x00, c_in=0, start pulse -> busy high 8 cycles, then done=1 for 1 cycle; S=0x00, c_out=0.
2. WIDTH=8, carry propagation:
   - A=0xFF, B=0x01, c_in=0 -> S=0x00, c_out=1
   - A=0xA5, B=0x5A, c_in=1 -> S=0x00, c_out=1
   - A=0x7F, B=0x01, c_in=0 -> S=0x80, c_out=0
   - check done at exactly start-edge+8, and S unchanged during busy.
3. Start while busy: start A=0x10, B=0x20, c_in=0; at cycle 3 pulse start with A=0xFF, B=0xFF and change the inputs -> single done, S=0x30, c_out=0. No second operation starts.
4. Reset mid-operation: start A=0xFF, B=0xFF, c_in=1; assert rst asynchronously (off-edge) at cycle 4 -> busy, done, S and c_out go to 0 immediately; no done pulse follows. A new start after release with A=0x01, B=0x02, c_in=0 -> S=0x03.
5. Back-to-back: start, then re-assert start at the first IDLE cycle after done -> second result correct. done pulses are separated by WIDTH+2 cycles.
6. Exhaustive, WIDTH=3: all A, B in 0..7 and c_in in {0,1} (128 cases) -> {c_out,S} == A+B+c_in for every case, checked against a behavioural reference in the bench.
